// File: rtl/crc_stream.sv
// Beat-parallel streaming CRC engine: DATA_W message bits per accepted beat,
// one registered result per frame on a valid/ready output with a beat count.
module crc_stream #(
  parameter int unsigned        CRC_W  = 16,
  parameter logic [CRC_W-1:0]   POLY   = CRC_W'(16'h8005),
  parameter logic [CRC_W-1:0]   INIT   = '0,
  parameter logic [CRC_W-1:0]   XOROUT = '0,
  parameter int unsigned        DATA_W = 8,
  parameter bit                 REFIN  = 1'b0,
  parameter bit                 REFOUT = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_last_i,
  output logic              crc_valid_o,
  input  logic              crc_ready_i,
  output logic [CRC_W-1:0]  crc_o,
  output logic [15:0]       len_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CRC_W-1:0]   crc_reg_q, crc_reg_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [CRC_W-1:0]   crc_out_q, crc_out_d;
  logic [15:0]        len_q, len_d;

  logic               beat_fire;
  logic [CRC_W-1:0]   crc_step;
  logic [15:0]        cnt_inc;

  // Unrolled shift-register division: DATA_W serial steps collapse into one cycle.
  function automatic logic [CRC_W-1:0] crc_advance(input logic [CRC_W-1:0] crc_in,
                                                   input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             b;
    c = crc_in;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      b = REFIN ? data[i] : data[DATA_W-1-i];
      c = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b) ? POLY : '0);
    end
    return c;
  endfunction

  function automatic logic [CRC_W-1:0] reflect(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < CRC_W; i++) begin
      r[i] = v[CRC_W-1-i];
    end
    return r;
  endfunction

  assign s_ready_o   = (state_q != ST_DONE);
  assign crc_valid_o = (state_q == ST_DONE);
  assign crc_o       = crc_out_q;
  assign len_o       = len_q;

  assign beat_fire = s_valid_i & s_ready_o;
  assign crc_step  = crc_advance(crc_reg_q, s_data_i);
  assign cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    crc_reg_d = crc_reg_q;
    cnt_d     = cnt_q;
    crc_out_d = crc_out_q;
    len_d     = len_q;

    if (clear_i) begin
      state_d   = ST_IDLE;
      crc_reg_d = INIT;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_RUN: begin
          if (beat_fire) begin
            if (s_last_i) begin
              state_d   = ST_DONE;
              crc_out_d = (REFOUT ? reflect(crc_step) : crc_step) ^ XOROUT;
              len_d     = cnt_inc;
              crc_reg_d = INIT;
              cnt_d     = '0;
            end else begin
              state_d   = ST_RUN;
              crc_reg_d = crc_step;
              cnt_d     = cnt_inc;
            end
          end
        end
        ST_DONE: begin
          if (crc_ready_i) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      crc_reg_q <= INIT;
      cnt_q     <= '0;
      crc_out_q <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      crc_reg_q <= crc_reg_d;
      cnt_q     <= cnt_d;
      crc_out_q <= crc_out_d;
      len_q     <= len_d;
    end
  end

endmodule

// File: tb/tb_crc_stream.sv
// Self-checking bench for crc_stream: four byte-wide CRC flavours driven in
// lockstep plus a bit-serial instance, checked against a frame-level model.
module tb_crc_stream;

  typedef logic [63:0] beat_q_t[$];

  typedef struct {
    string       txt;
    logic [15:0] e_def;
    logic [15:0] e_arc;
    logic [15:0] e_cc;
    logic [31:0] e_32;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, clear, s_valid, s_last, crc_ready;
  logic [7:0]  s_data;
  logic        b_valid, b_last;
  logic [0:0]  b_data;

  logic        rdy_def, rdy_arc, rdy_cc, rdy_32, b_rdy;
  logic        v_def, v_arc, v_cc, v_32, b_v;
  logic [15:0] crc_def, crc_arc, crc_cc, b_crc;
  logic [31:0] crc_32;
  logic [15:0] len_def, len_arc, len_cc, len_32, b_len;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  crc_stream u_def (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .s_valid_i(s_valid), .s_ready_o(rdy_def), .s_data_i(s_data), .s_last_i(s_last),
    .crc_valid_o(v_def), .crc_ready_i(crc_ready), .crc_o(crc_def), .len_o(len_def)
  );

  crc_stream #(.REFIN(1'b1), .REFOUT(1'b1)) u_arc (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .s_valid_i(s_valid), .s_ready_o(rdy_arc), .s_data_i(s_data), .s_last_i(s_last),
    .crc_valid_o(v_arc), .crc_ready_i(crc_ready), .crc_o(crc_arc), .len_o(len_arc)
  );

  crc_stream #(.POLY(16'h1021), .INIT(16'hFFFF)) u_cc (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .s_valid_i(s_valid), .s_ready_o(rdy_cc), .s_data_i(s_data), .s_last_i(s_last),
    .crc_valid_o(v_cc), .crc_ready_i(crc_ready), .crc_o(crc_cc), .len_o(len_cc)
  );

  crc_stream #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
               .XOROUT(32'hFFFFFFFF), .REFIN(1'b1), .REFOUT(1'b1)) u_32 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .s_valid_i(s_valid), .s_ready_o(rdy_32), .s_data_i(s_data), .s_last_i(s_last),
    .crc_valid_o(v_32), .crc_ready_i(crc_ready), .crc_o(crc_32), .len_o(len_32)
  );

  crc_stream #(.DATA_W(1)) u_bit (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .s_valid_i(b_valid), .s_ready_o(b_rdy), .s_data_i(b_data), .s_last_i(b_last),
    .crc_valid_o(b_v), .crc_ready_i(crc_ready), .crc_o(b_crc), .len_o(b_len)
  );

  // Frame-level reference: whole message as a bit sequence, long division by POLY.
  function automatic logic [63:0] model_crc(input int unsigned w, input logic [63:0] poly,
                                            input logic [63:0] init, input logic [63:0] xorout,
                                            input bit refin, input bit refout,
                                            input int unsigned dw, input beat_q_t msg);
    logic [63:0] mask, r, rr, beat;
    bit          bits[$];
    mask = (64'd1 << w) - 64'd1;
    foreach (msg[k]) begin
      beat = msg[k];
      for (int unsigned j = 0; j < dw; j++)
        bits.push_back(refin ? beat[j] : beat[dw-1-j]);
    end
    r = init & mask;
    foreach (bits[k]) begin
      if ((((r >> (w - 1)) & 64'd1) != 64'd0) != bits[k])
        r = ((r << 1) & mask) ^ poly;
      else
        r = (r << 1) & mask;
    end
    if (refout) begin
      rr = '0;
      for (int unsigned i = 0; i < w; i++) rr[i] = r[w-1-i];
      r = rr;
    end
    return (r ^ xorout) & mask;
  endfunction

  function automatic beat_q_t str2q(input string s);
    beat_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(64'(s[i]));
    return q;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input beat_q_t msg, input bit bitlane, input bit gaps, input bit do_last);
    int unsigned budget;
    for (int i = 0; i < msg.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          if (bitlane) begin
            b_valid = 1'b0; b_data = 1'($urandom); b_last = 1'($urandom);
          end else begin
            s_valid = 1'b0; s_data = 8'($urandom); s_last = 1'($urandom);
          end
          tick();
        end
      end
      if (bitlane) begin
        b_valid = 1'b1; b_data = msg[i][0:0]; b_last = do_last && (i == msg.size() - 1);
      end else begin
        s_valid = 1'b1; s_data = msg[i][7:0]; s_last = do_last && (i == msg.size() - 1);
      end
      budget = 0;
      while (!(bitlane ? b_rdy : rdy_def) && budget < 20) begin
        tick();
        budget++;
      end
      if (budget >= 20) begin
        n_cmp++; n_bad++;
        $display("FAIL ready_timeout: s_ready_o stayed 0, required 1");
      end
      tick();
    end
    s_valid = 1'b0; s_last = 1'b0;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  // Call right after the last beat was accepted; checks result, then the handshake.
  task automatic check_bytes(input string tag, input logic [15:0] e_def, input logic [15:0] e_arc,
                             input logic [15:0] e_cc, input logic [31:0] e_32, input int unsigned len);
    @(negedge clk);
    check({tag, "_valid"}, 64'(v_def), 64'd1);
    check({tag, "_valid32"}, 64'(v_32), 64'd1);
    check({tag, "_crc_def"}, 64'(crc_def), 64'(e_def));
    check({tag, "_crc_arc"}, 64'(crc_arc), 64'(e_arc));
    check({tag, "_crc_ccitt"}, 64'(crc_cc), 64'(e_cc));
    check({tag, "_crc_32"}, 64'(crc_32), 64'(e_32));
    check({tag, "_len"}, 64'(len_def), 64'(len));
    check({tag, "_len32"}, 64'(len_32), 64'(len));
    tick();
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(v_def), 64'd0);
    check({tag, "_ready_back"}, 64'(rdy_def), 64'd1);
  endtask

  task automatic check_bit(input string tag, input logic [15:0] e, input int unsigned len);
    @(negedge clk);
    check({tag, "_valid"}, 64'(b_v), 64'd1);
    check({tag, "_crc"}, 64'(b_crc), 64'(e));
    check({tag, "_len"}, 64'(b_len), 64'(len));
    tick();
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(b_v), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[4];
    beat_q_t     q;
    logic [31:0] w;
    int unsigned n;

    vecs[0] = '{txt: "123456789", e_def: 16'hFEE8, e_arc: 16'hBB3D, e_cc: 16'h29B1, e_32: 32'hCBF43926};
    vecs[1].txt = "A";
    vecs[2].txt = "hello, world";
    vecs[3].txt = "\x00\xff\x80\x01";
    for (int i = 1; i < 4; i++) begin
      q = str2q(vecs[i].txt);
      vecs[i].e_def = 16'(model_crc(16, 64'h8005, 0, 0, 0, 0, 8, q));
      vecs[i].e_arc = 16'(model_crc(16, 64'h8005, 0, 0, 1, 1, 8, q));
      vecs[i].e_cc  = 16'(model_crc(16, 64'h1021, 64'hFFFF, 0, 0, 0, 8, q));
      vecs[i].e_32  = 32'(model_crc(32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 1, 8, q));
    end

    rst_n = 1'b0; clear = 1'b0; crc_ready = 1'b1;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("reset_valid", 64'(v_def), 64'd0);
    check("reset_crc", 64'(crc_def), 64'd0);
    check("reset_len", 64'(len_def), 64'd0);
    check("reset_ready", 64'(rdy_def), 64'd1);
    check("reset_bit_valid", 64'(b_v), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      send(str2q(vecs[i].txt), 1'b0, 1'b0, 1'b1);
      check_bytes($sformatf("vec%0d", i), vecs[i].e_def, vecs[i].e_arc, vecs[i].e_cc,
                  vecs[i].e_32, vecs[i].txt.len());
    end

    for (int f = 0; f < 20; f++) begin
      q.delete();
      n = $urandom_range(1, 12);
      for (int unsigned k = 0; k < n; k++) q.push_back(64'($urandom_range(0, 255)));
      send(q, 1'b0, 1'b1, 1'b1);
      check_bytes($sformatf("rnd%0d", f),
                  16'(model_crc(16, 64'h8005, 0, 0, 0, 0, 8, q)),
                  16'(model_crc(16, 64'h8005, 0, 0, 1, 1, 8, q)),
                  16'(model_crc(16, 64'h1021, 64'hFFFF, 0, 0, 0, 8, q)),
                  32'(model_crc(32, 64'h04C11DB7, 64'hFFFFFFFF, 64'hFFFFFFFF, 1, 1, 8, q)), n);
    end

    for (int f = 0; f < 3; f++) begin
      q.delete();
      w = $urandom;
      for (int i = 31; i >= 0; i--) q.push_back(64'(w[i]));
      send(q, 1'b1, 1'b1, 1'b1);
      check_bit($sformatf("bit%0d", f), 16'(model_crc(16, 64'h8005, 0, 0, 0, 0, 1, q)), 32);
    end
    q.delete();
    foreach (vecs[0].txt[c]) begin
      for (int i = 7; i >= 0; i--) q.push_back(64'((vecs[0].txt[c] >> i) & 1));
    end
    send(q, 1'b1, 1'b0, 1'b1);
    check_bit("bit_check", 16'hFEE8, 72);

    crc_ready = 1'b0;
    send(str2q("123456789"), 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d_crc", k), 64'(crc_def), 64'hFEE8);
      check($sformatf("hold%0d_len", k), 64'(len_def), 64'd9);
      check($sformatf("hold%0d_valid", k), 64'(v_def), 64'd1);
      check($sformatf("hold%0d_ready", k), 64'(rdy_def), 64'd0);
    end
    crc_ready = 1'b1;
    tick();
    @(negedge clk);
    check("hold_release_valid", 64'(v_def), 64'd0);

    send(str2q("abcd"), 1'b0, 1'b0, 1'b0);
    clear = 1'b1; s_valid = 1'b1; s_data = 8'h5A; s_last = 1'b1;
    tick();
    clear = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    check("clear_valid", 64'(v_def), 64'd0);
    check("clear_ready", 64'(rdy_def), 64'd1);
    send(str2q("123456789"), 1'b0, 1'b0, 1'b1);
    check_bytes("after_clear", 16'hFEE8, 16'hBB3D, 16'h29B1, 32'hCBF43926, 9);

    crc_ready = 1'b0;
    send(str2q("123456789"), 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("pre_rst_valid", 64'(v_def), 64'd1);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("rst_done_valid", 64'(v_def), 64'd0);
    check("rst_done_crc", 64'(crc_def), 64'd0);
    check("rst_done_len", 64'(len_def), 64'd0);
    check("rst_done_ready", 64'(rdy_def), 64'd1);
    rst_n = 1'b1;
    crc_ready = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
